// File: rtl/axi_crossbar_slv_arb.sv
// Write-address arbiter and in-order write-data steering for one crossbar slave port.
// Optional macro AXI_XBAR_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority.
module axi_crossbar_slv_arb #(
    parameter int NUM_MST  = 4,
    parameter int AWCH_W   = 53,
    parameter int WCH_W    = 47,
    parameter int OSTD_NUM = 4
) (
    input  logic                      i_aclk,
    input  logic                      i_srst,
    input  logic [NUM_MST-1:0]        m_awvalid,
    output logic [NUM_MST-1:0]        m_awready,
    input  logic [NUM_MST*AWCH_W-1:0] m_awch,
    input  logic [NUM_MST-1:0]        m_wvalid,
    output logic [NUM_MST-1:0]        m_wready,
    input  logic [NUM_MST*WCH_W-1:0]  m_wch,
    input  logic [NUM_MST-1:0]        m_wlast,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [AWCH_W-1:0]         s_awch,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    output logic [WCH_W-1:0]          s_wch,
    output logic                      s_wlast
);
    localparam int IDX_W = $clog2(NUM_MST);
    localparam int ADR_W = $clog2(OSTD_NUM);
    localparam int PTR_W = ADR_W + 1;

    typedef enum logic {ST_IDLE, ST_HOLD} aw_state_t;

    aw_state_t        state;
    aw_state_t        state_nxt;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] order_mem [OSTD_NUM];
    logic [IDX_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             w_route;

`ifdef AXI_XBAR_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // Scan offsets high-to-low so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (m_awvalid[IDX_W'((int'(rr_ptr) + i) % NUM_MST)])
                grant_idx = IDX_W'((int'(rr_ptr) + i) % NUM_MST);
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_srst)
            rr_ptr <= '0;
        else if (grant_en)
            rr_ptr <= (grant_idx == IDX_W'(NUM_MST - 1)) ? '0 : grant_idx + 1'b1;
    end
`else
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (m_awvalid[i])
                grant_idx = IDX_W'(i);
        end
    end
`endif

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADR_W] != rd_ptr[ADR_W]) &&
                        (wr_ptr[ADR_W-1:0] == rd_ptr[ADR_W-1:0]);
    // A full FIFO blocks the grant even when a pop lands in the same cycle.
    assign grant_en   = (state == ST_IDLE) && (|m_awvalid) && !fifo_full && !i_srst;

    always_comb begin
        state_nxt = state;
        m_awready = '0;
        case (state)
            ST_IDLE: begin
                if (grant_en) begin
                    m_awready[grant_idx] = 1'b1;
                    state_nxt            = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (s_awready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            state  <= ST_IDLE;
            s_awch <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en)
                s_awch <= m_awch[int'(grant_idx)*AWCH_W +: AWCH_W];
        end
    end

    assign s_awvalid = (state == ST_HOLD);

    // NOTE: the order memory has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_aclk) begin
        if (grant_en)
            order_mem[wr_ptr[ADR_W-1:0]] <= grant_idx;
    end

    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (grant_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head     = order_mem[rd_ptr[ADR_W-1:0]];
    assign w_route  = !fifo_empty && !i_srst;
    assign s_wch    = m_wch[int'(head)*WCH_W +: WCH_W];
    assign s_wlast  = m_wlast[head];
    assign s_wvalid = w_route && m_wvalid[head];
    assign fifo_pop = s_wvalid && s_wready && s_wlast;

    always_comb begin
        m_wready = '0;
        if (w_route)
            m_wready[head] = s_wready;
    end

endmodule

// File: tb/tb_axi_crossbar_slv_arb.sv
// Self-checking bench for axi_crossbar_slv_arb: grant table, W ordering, full FIFO and mid-op reset.
// Expectations follow AXI_XBAR_ARB_RR_EN when it is defined for the build.
module tb_axi_crossbar_slv_arb;
    localparam int NUM_MST  = 4;
    localparam int AWCH_W   = 53;
    localparam int WCH_W    = 47;
    localparam int OSTD_NUM = 4;
`ifdef AXI_XBAR_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct {
        logic [3:0] awv;
        logic       sar;
        logic [3:0] exp_awr;
        logic       exp_sav;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      i_srst;
    logic [NUM_MST-1:0]        m_awvalid;
    logic [NUM_MST-1:0]        m_awready;
    logic [NUM_MST*AWCH_W-1:0] m_awch;
    logic [NUM_MST-1:0]        m_wvalid;
    logic [NUM_MST-1:0]        m_wready;
    logic [NUM_MST*WCH_W-1:0]  m_wch;
    logic [NUM_MST-1:0]        m_wlast;
    logic                      s_awvalid;
    logic                      s_awready;
    logic [AWCH_W-1:0]         s_awch;
    logic                      s_wvalid;
    logic                      s_wready;
    logic [WCH_W-1:0]          s_wch;
    logic                      s_wlast;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] aw_q[$];
    logic [63:0] w_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    axi_crossbar_slv_arb #(
        .NUM_MST (NUM_MST),
        .AWCH_W  (AWCH_W),
        .WCH_W   (WCH_W),
        .OSTD_NUM(OSTD_NUM)
    ) dut (
        .i_aclk   (clk),
        .i_srst   (i_srst),
        .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_awch   (m_awch),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .m_wch    (m_wch),
        .m_wlast  (m_wlast),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_awch   (s_awch),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_wch    (s_wch),
        .s_wlast  (s_wlast)
    );

    function automatic logic [AWCH_W-1:0] aw_pay(input int k);
        return AWCH_W'(64'h000F_1234_5678_9AB0 + 64'(k) * 64'h0000_0001_0000_0101);
    endfunction

    function automatic logic [WCH_W-1:0] w_pay(input int k, input int b);
        return WCH_W'(64'h0000_3000_0000_0000 + 64'(k) * 64'h0000_0001_0001_0000 + 64'(b));
    endfunction

    function automatic logic [63:0] w_exp(input int k, input int b, input logic last);
        return 64'({last, w_pay(k, b)});
    endfunction

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++)
            if (oh[i]) return i;
        return 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] awv, input logic sar, input logic [3:0] rr,
                       input logic [3:0] fp, input logic sav);
        vec_t v;
        v.awv     = awv;
        v.sar     = sar;
        v.exp_awr = RR_MODE ? rr : fp;
        v.exp_sav = sav;
        tbl.push_back(v);
    endtask

    task automatic drive_w(input int k, input int b, input logic last);
        m_wch[k*WCH_W +: WCH_W] = w_pay(k, b);
        m_wlast[k]              = last;
    endtask

    // Scoreboard pop side: every slave-side handshake must match the oldest expectation.
    task automatic mon();
        logic [63:0] e;
        if (s_awvalid && s_awready) begin
            if (aw_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL aw_extra: got %0h expected no handshake at %0t", s_awch, $time);
            end else begin
                e = aw_q.pop_front();
                check("aw_payload", 64'(s_awch), e);
            end
        end
        if (s_wvalid && s_wready) begin
            if (w_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL w_extra: got %0h expected no handshake at %0t", s_wch, $time);
            end else begin
                e = w_q.pop_front();
                check("w_beat", 64'({s_wlast, s_wch}), e);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Grant table: {awvalid, s_awready, expected grant RR, expected grant FP, s_awvalid}
        add(4'b1111, 1, 4'b0001, 4'b0001, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0010, 4'b0001, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0100, 4'b0001, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b1000, 4'b0001, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0001, 4'b0001, 0);
        add(4'b1111, 1, 4'b0000, 4'b0000, 1);
        add(4'b1001, 1, 4'b1000, 4'b0001, 0);
        add(4'b1001, 1, 4'b0000, 4'b0000, 1);
        add(4'b1001, 1, 4'b0001, 4'b0001, 0);
        add(4'b1001, 1, 4'b0000, 4'b0000, 1);
        add(4'b0000, 1, 4'b0000, 4'b0000, 0);
        add(4'b0000, 1, 4'b0000, 4'b0000, 0);
        add(4'b1100, 0, 4'b0100, 4'b0100, 0);
        add(4'b1100, 0, 4'b0000, 4'b0000, 1);
        add(4'b1100, 1, 4'b0000, 4'b0000, 1);
        add(4'b1100, 1, 4'b1000, 4'b0100, 0);
        add(4'b1100, 1, 4'b0000, 4'b0000, 1);

        i_srst    = 1'b1;
        m_awvalid = '1;
        m_wvalid  = '0;
        m_wlast   = '0;
        m_wch     = '0;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        for (int k = 0; k < NUM_MST; k++)
            m_awch[k*AWCH_W +: AWCH_W] = aw_pay(k);

        // Reset held three cycles with every master requesting.
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rst_s_awvalid", 64'(s_awvalid), 0);
            check("rst_m_awready", 64'(m_awready), 0);
            check("rst_m_wready", 64'(m_wready), 0);
            check("rst_s_wvalid", 64'(s_wvalid), 0);
            adv();
        end

        // Grant table with every master offering a single-beat W so the FIFO drains.
        i_srst   = 1'b0;
        m_wvalid = '1;
        for (int k = 0; k < NUM_MST; k++)
            drive_w(k, 0, 1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            m_awvalid = tbl[i].awv;
            s_awready = tbl[i].sar;
            settle();
            check($sformatf("vec%0d_m_awready", i), 64'(m_awready), 64'(tbl[i].exp_awr));
            check($sformatf("vec%0d_s_awvalid", i), 64'(s_awvalid), 64'(tbl[i].exp_sav));
            check($sformatf("vec%0d_m_wready", i), 64'(m_wready),
                  (i > 0) ? 64'(tbl[i-1].exp_awr) : 64'd0);
            if (tbl[i].exp_awr != 4'b0000) begin
                aw_q.push_back(64'(aw_pay(oh2idx(tbl[i].exp_awr))));
                w_q.push_back(w_exp(oh2idx(tbl[i].exp_awr), 0, 1'b1));
            end
            adv();
        end

        // W ordering: grant master 2 then master 1; master 1 offers data first.
        m_wvalid  = '0;
        m_wlast   = '0;
        s_awready = 1'b1;
        m_awvalid = 4'b0100;
        settle();
        check("ord_grant2", 64'(m_awready), 64'(4'b0100));
        check("ord_empty_wready", 64'(m_wready), 0);
        aw_q.push_back(64'(aw_pay(2)));
        adv();
        m_awvalid = 4'b0000;
        settle();
        check("ord_hold1", 64'(s_awvalid), 1);
        adv();
        m_awvalid = 4'b0010;
        m_wvalid  = 4'b0010;
        drive_w(1, 0, 1'b0);
        settle();
        check("ord_grant1", 64'(m_awready), 64'(4'b0010));
        check("ord_m1_blocked_a", 64'(m_wready), 64'(4'b0100));
        check("ord_s_wvalid_a", 64'(s_wvalid), 0);
        aw_q.push_back(64'(aw_pay(1)));
        adv();
        m_awvalid = 4'b0000;
        settle();
        check("ord_m1_blocked_b", 64'(m_wready), 64'(4'b0100));
        check("ord_s_wvalid_b", 64'(s_wvalid), 0);
        adv();
        for (int b = 0; b < 4; b++) w_q.push_back(w_exp(2, b, b == 3));
        for (int b = 0; b < 4; b++) w_q.push_back(w_exp(1, b, b == 3));
        m_wvalid = 4'b0110;
        for (int b = 0; b < 4; b++) begin
            drive_w(2, b, b == 3);
            settle();
            check($sformatf("ord_m2_beat%0d_wready", b), 64'(m_wready), 64'(4'b0100));
            adv();
        end
        m_wvalid = 4'b0010;
        m_wlast  = '0;
        for (int b = 0; b < 4; b++) begin
            drive_w(1, b, b == 3);
            if (b == 2) begin
                s_wready = 1'b0;
                settle();
                check("ord_stall_wready", 64'(m_wready), 0);
                check("ord_stall_wvalid", 64'(s_wvalid), 1);
                adv();
                s_wready = 1'b1;
            end
            settle();
            check($sformatf("ord_m1_beat%0d_wready", b), 64'(m_wready), 64'(4'b0010));
            adv();
        end

        // Full FIFO: four grants to master 0 with no W, then a fifth request.
        m_wvalid  = '0;
        m_wlast   = '0;
        m_awvalid = 4'b0001;
        for (int n = 0; n < OSTD_NUM; n++) begin
            settle();
            check($sformatf("full_grant%0d", n), 64'(m_awready), 64'(4'b0001));
            aw_q.push_back(64'(aw_pay(0)));
            adv();
            settle();
            check($sformatf("full_hold%0d", n), 64'(m_awready), 0);
            adv();
        end
        settle();
        check("full_no_grant", 64'(m_awready), 0);
        check("full_s_awvalid", 64'(s_awvalid), 0);
        adv();
        m_wvalid[0] = 1'b1;
        drive_w(0, 7, 1'b1);
        w_q.push_back(w_exp(0, 7, 1'b1));
        settle();
        check("full_pop_no_grant", 64'(m_awready), 0);
        check("full_pop_wready", 64'(m_wready), 64'(4'b0001));
        adv();
        m_wvalid = '0;
        settle();
        check("full_grant_after_pop", 64'(m_awready), 64'(4'b0001));
        aw_q.push_back(64'(aw_pay(0)));
        adv();
        m_awvalid = '0;
        settle();
        check("full_hold_after_pop", 64'(s_awvalid), 1);
        adv();

        // Reset pulse clears the four queued entries.
        i_srst = 1'b1;
        settle();
        check("pulse_m_awready", 64'(m_awready), 0);
        adv();
        i_srst = 1'b0;
        settle();
        check("pulse_fifo_empty", 64'(m_wready), 0);
        adv();

        // Mid-op reset: HOLD with two entries queued.
        m_awvalid = 4'b1000;
        settle();
        check("mid_grant3", 64'(m_awready), 64'(4'b1000));
        aw_q.push_back(64'(aw_pay(3)));
        adv();
        m_awvalid = '0;
        settle();
        adv();
        m_awvalid = 4'b0100;
        s_awready = 1'b0;
        settle();
        check("mid_grant2", 64'(m_awready), 64'(4'b0100));
        aw_q.push_back(64'(aw_pay(2)));
        adv();
        m_awvalid = '0;
        i_srst    = 1'b1;
        settle();
        check("mid_rst_in_hold", 64'(s_awvalid), 1);
        check("mid_rst_awready", 64'(m_awready), 0);
        adv();
        aw_q.delete();
        i_srst      = 1'b0;
        s_awready   = 1'b1;
        m_wvalid    = 4'b1000;
        drive_w(3, 0, 1'b1);
        settle();
        check("mid_post_s_awvalid", 64'(s_awvalid), 0);
        check("mid_post_m_wready", 64'(m_wready), 0);
        check("mid_post_s_wvalid", 64'(s_wvalid), 0);
        adv();
        m_wvalid  = '0;
        m_awvalid = 4'b0010;
        settle();
        check("mid_regrant", 64'(m_awready), 64'(4'b0010));
        aw_q.push_back(64'(aw_pay(1)));
        w_q.push_back(w_exp(1, 0, 1'b1));
        adv();
        m_awvalid = '0;
        m_wvalid  = 4'b0010;
        drive_w(1, 0, 1'b1);
        settle();
        check("mid_regrant_wready", 64'(m_wready), 64'(4'b0010));
        adv();
        m_wvalid = '0;

        check("aw_q_drained", 64'(aw_q.size()), 0);
        check("w_q_drained", 64'(w_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
